// File: rtl/bcd_field_counter.sv
// -----------------------------------------------------------------------------
// bcd_field_counter
//
// One BCD time/date field (seconds, minutes, hours, day, month, year) of the
// calendar datapath. The value counts trigger pulses up or down between a
// fixed minimum and a limit. The limit is either static or, for fields such as
// day-of-month, supplied at runtime. The counter also supports whole-field
// adjust, parallel load with range checking, and clamping when the limit drops
// below the current value. On wrap it emits a one-cycle carry/borrow pulse
// that feeds the trigger input of the next field.
//
// Parameters
//   PAR_DIGITS     number of BCD digits (1-4)
//   PAR_MIN_BCD    packed BCD minimum value
//   PAR_MAX_BCD    packed BCD default limit
//   PAR_EXT_LIMIT  1 = take the limit from I_LIMIT_BCD when it is usable
//
// Ports
//   I_SYS_CLK    in   system clock, all state on the rising edge
//   I_EXT_RST    in   synchronous active-high reset
//   I_TRIG_F     in   count pulse (carry/borrow from the lower field)
//   I_DIR        in   0 = count up on trigger, 1 = count down
//   I_ADJ_UP     in   adjust +1 without carry
//   I_ADJ_DOWN   in   adjust -1 without borrow
//   I_LOAD       in   parallel load strobe
//   I_LOAD_BCD   in   load value (packed BCD)
//   I_LIMIT_BCD  in   runtime limit (packed BCD)
//   O_VALUE_BCD  out  current value, registered
//   O_TRIG_F     out  one-cycle carry/borrow pulse, registered
//   O_LOAD_ERR   out  one-cycle pulse when a load is rejected, registered
//   O_AT_LIMIT   out  combinational: value equals the effective limit
// -----------------------------------------------------------------------------
module bcd_field_counter #(
  parameter int PAR_DIGITS    = 2,
  parameter int PAR_MIN_BCD   = 'h00,
  parameter int PAR_MAX_BCD   = 'h59,
  parameter int PAR_EXT_LIMIT = 0
) (
  input  logic                    I_SYS_CLK,
  input  logic                    I_EXT_RST,
  input  logic                    I_TRIG_F,
  input  logic                    I_DIR,
  input  logic                    I_ADJ_UP,
  input  logic                    I_ADJ_DOWN,
  input  logic                    I_LOAD,
  input  logic [4*PAR_DIGITS-1:0] I_LOAD_BCD,
  input  logic [4*PAR_DIGITS-1:0] I_LIMIT_BCD,
  output logic [4*PAR_DIGITS-1:0] O_VALUE_BCD,
  output logic                    O_TRIG_F,
  output logic                    O_LOAD_ERR,
  output logic                    O_AT_LIMIT
);

  localparam int W = 4 * PAR_DIGITS;
  localparam logic [W-1:0] MIN_BCD = PAR_MIN_BCD[W-1:0];
  localparam logic [W-1:0] MAX_BCD = PAR_MAX_BCD[W-1:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0] value_reg;
  logic [W-1:0] value_next;
  logic         trig_reg;
  logic         trig_next;
  logic         load_err_reg;
  logic         load_err_next;

  // ---------------------------------------------------------------------------
  // Per-digit BCD validity of the load value and the runtime limit
  // ---------------------------------------------------------------------------
  logic [PAR_DIGITS-1:0] load_digit_ok;
  logic [PAR_DIGITS-1:0] limit_digit_ok;

  genvar gi;
  generate
    for (gi = 0; gi < PAR_DIGITS; gi = gi + 1) begin : g_digit_check
      assign load_digit_ok[gi]  = (I_LOAD_BCD[4*gi +: 4]  <= 4'd9);
      assign limit_digit_ok[gi] = (I_LIMIT_BCD[4*gi +: 4] <= 4'd9);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Effective limit. A runtime limit that is malformed or below the minimum
  // would make the range empty, so fall back to the static limit instead.
  // ---------------------------------------------------------------------------
  logic         limit_ok;
  logic [W-1:0] eff_limit;

  assign limit_ok  = (PAR_EXT_LIMIT != 0) && (&limit_digit_ok) &&
                     (I_LIMIT_BCD >= MIN_BCD);
  assign eff_limit = limit_ok ? I_LIMIT_BCD : MAX_BCD;

  // ---------------------------------------------------------------------------
  // Comparisons. Valid packed BCD orders the same way as its decimal value,
  // so plain unsigned compares are enough.
  // ---------------------------------------------------------------------------
  logic at_limit;
  logic at_min;
  logic above_limit;
  logic load_ok;

  assign at_limit    = (value_reg == eff_limit);
  assign at_min      = (value_reg == MIN_BCD);
  assign above_limit = (value_reg > eff_limit);
  assign load_ok     = (&load_digit_ok) && (I_LOAD_BCD >= MIN_BCD) &&
                       (I_LOAD_BCD <= eff_limit);

  // ---------------------------------------------------------------------------
  // BCD ripple increment / decrement. The carry (or borrow) moves up through
  // the digits for as long as each digit wraps. It stops at the first digit
  // that does not wrap.
  // ---------------------------------------------------------------------------
  logic [W-1:0] value_inc;
  logic [W-1:0] value_dec;

  always_comb begin
    logic carry;
    carry     = 1'b1;
    value_inc = value_reg;
    for (int i = 0; i < PAR_DIGITS; i++) begin
      if (carry) begin
        if (value_reg[4*i +: 4] == 4'd9) begin
          value_inc[4*i +: 4] = 4'd0;
        end else begin
          value_inc[4*i +: 4] = value_reg[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    logic borrow;
    borrow    = 1'b1;
    value_dec = value_reg;
    for (int i = 0; i < PAR_DIGITS; i++) begin
      if (borrow) begin
        if (value_reg[4*i +: 4] == 4'd0) begin
          value_dec[4*i +: 4] = 4'd9;
        end else begin
          value_dec[4*i +: 4] = value_reg[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state selection. Only one action is taken per cycle. A trigger that
  // loses to load, adjust or clamp is dropped rather than deferred, because
  // the field has already been repositioned explicitly.
  // ---------------------------------------------------------------------------
  always_comb begin
    value_next    = value_reg;
    trig_next     = 1'b0;
    load_err_next = 1'b0;

    if (I_LOAD) begin
      if (load_ok) begin
        value_next = I_LOAD_BCD;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (I_ADJ_UP) begin
      value_next = at_limit ? MIN_BCD : value_inc;
    end else if (I_ADJ_DOWN) begin
      value_next = at_min ? eff_limit : value_dec;
    end else if (above_limit) begin
      // The limit dropped under the value (e.g. day 31 in a 30-day month).
      // Pull the value down to the limit without a carry.
      value_next = eff_limit;
    end else if (I_TRIG_F) begin
      if (!I_DIR) begin
        if (at_limit) begin
          value_next = MIN_BCD;
          trig_next  = 1'b1;
        end else begin
          value_next = value_inc;
        end
      end else begin
        if (at_min) begin
          value_next = eff_limit;
          trig_next  = 1'b1;
        end else begin
          value_next = value_dec;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_SYS_CLK) begin
    if (I_EXT_RST) begin
      value_reg    <= MIN_BCD;
      trig_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      value_reg    <= value_next;
      trig_reg     <= trig_next;
      load_err_reg <= load_err_next;
    end
  end

  assign O_VALUE_BCD = value_reg;
  assign O_TRIG_F    = trig_reg;
  assign O_LOAD_ERR  = load_err_reg;
  assign O_AT_LIMIT  = at_limit;

endmodule

// File: tb/tb_bcd_field_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_field_counter
//
// Three instances share one clock:
//   0: defaults (2 digits, 00..59, static limit)
//   1: day-style field (min 01, default limit 31, runtime limit enabled)
//   2: 3-digit field (000..999)
// A decimal-level reference model tracks every instance and is compared on
// each falling edge. Directed literal checks pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_bcd_field_counter;

  logic clk;
  logic rst [3];
  logic trg [3];
  logic dir [3];
  logic aup [3];
  logic adn [3];
  logic ld  [3];
  logic [15:0] ldv [3];
  logic [15:0] lim [3];

  logic [7:0]  val_a, val_b;
  logic [11:0] val_c;
  logic trig_a, trig_b, trig_c;
  logic err_a, err_b, err_c;
  logic atl_a, atl_b, atl_c;

  // Model configuration in plain decimal
  int p_min [3] = '{0, 1, 0};
  int p_max [3] = '{59, 31, 999};
  int p_ext [3] = '{0, 1, 0};
  int p_dig [3] = '{2, 2, 3};

  int m_val  [3];
  bit m_trig [3];
  bit m_err  [3];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  bcd_field_counter #(
    .PAR_DIGITS(2), .PAR_MIN_BCD('h00), .PAR_MAX_BCD('h59), .PAR_EXT_LIMIT(0)
  ) u_a (
    .I_SYS_CLK(clk), .I_EXT_RST(rst[0]), .I_TRIG_F(trg[0]), .I_DIR(dir[0]),
    .I_ADJ_UP(aup[0]), .I_ADJ_DOWN(adn[0]), .I_LOAD(ld[0]),
    .I_LOAD_BCD(ldv[0][7:0]), .I_LIMIT_BCD(lim[0][7:0]),
    .O_VALUE_BCD(val_a), .O_TRIG_F(trig_a), .O_LOAD_ERR(err_a), .O_AT_LIMIT(atl_a)
  );

  bcd_field_counter #(
    .PAR_DIGITS(2), .PAR_MIN_BCD('h01), .PAR_MAX_BCD('h31), .PAR_EXT_LIMIT(1)
  ) u_b (
    .I_SYS_CLK(clk), .I_EXT_RST(rst[1]), .I_TRIG_F(trg[1]), .I_DIR(dir[1]),
    .I_ADJ_UP(aup[1]), .I_ADJ_DOWN(adn[1]), .I_LOAD(ld[1]),
    .I_LOAD_BCD(ldv[1][7:0]), .I_LIMIT_BCD(lim[1][7:0]),
    .O_VALUE_BCD(val_b), .O_TRIG_F(trig_b), .O_LOAD_ERR(err_b), .O_AT_LIMIT(atl_b)
  );

  bcd_field_counter #(
    .PAR_DIGITS(3), .PAR_MIN_BCD('h000), .PAR_MAX_BCD('h999), .PAR_EXT_LIMIT(0)
  ) u_c (
    .I_SYS_CLK(clk), .I_EXT_RST(rst[2]), .I_TRIG_F(trg[2]), .I_DIR(dir[2]),
    .I_ADJ_UP(aup[2]), .I_ADJ_DOWN(adn[2]), .I_LOAD(ld[2]),
    .I_LOAD_BCD(ldv[2][11:0]), .I_LIMIT_BCD(lim[2][11:0]),
    .O_VALUE_BCD(val_c), .O_TRIG_F(trig_c), .O_LOAD_ERR(err_c), .O_AT_LIMIT(atl_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Helpers: BCD <-> integer
  // ---------------------------------------------------------------------------
  function automatic bit bcd_ok(input int bcd, input int nd);
    for (int i = 0; i < nd; i++) begin
      if (((bcd >> (4 * i)) & 15) > 9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int bcd2int(input int bcd, input int nd);
    int r = 0;
    int m = 1;
    for (int i = 0; i < nd; i++) begin
      r = r + ((bcd >> (4 * i)) & 15) * m;
      m = m * 10;
    end
    return r;
  endfunction

  function automatic int int2bcd(input int v, input int nd);
    int r = 0;
    int x = v;
    for (int i = 0; i < nd; i++) begin
      r = r | ((x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int eff_lim(input int k);
    int lb = int'(lim[k]);
    if (p_ext[k] != 0 && bcd_ok(lb, p_dig[k]) && bcd2int(lb, p_dig[k]) >= p_min[k])
      return bcd2int(lb, p_dig[k]);
    return p_max[k];
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: one decimal step per rising edge
  // ---------------------------------------------------------------------------
  task automatic model_step(input int k);
    int lv  = eff_lim(k);
    int v   = m_val[k];
    int md  = 1;
    int d;
    bit t   = 1'b0;
    bit e   = 1'b0;
    for (int i = 0; i < p_dig[k]; i++) md = md * 10;
    d = bcd2int(int'(ldv[k]), p_dig[k]);
    if (rst[k]) begin
      v = p_min[k];
    end else if (ld[k]) begin
      if (bcd_ok(int'(ldv[k]), p_dig[k]) && d >= p_min[k] && d <= lv) v = d;
      else e = 1'b1;
    end else if (aup[k]) begin
      v = (v == lv) ? p_min[k] : (v + 1) % md;
    end else if (adn[k]) begin
      v = (v == p_min[k]) ? lv : v - 1;
    end else if (v > lv) begin
      v = lv;
    end else if (trg[k]) begin
      if (!dir[k]) begin
        if (v == lv) begin v = p_min[k]; t = 1'b1; end
        else v = (v + 1) % md;
      end else begin
        if (v == p_min[k]) begin v = lv; t = 1'b1; end
        else v = v - 1;
      end
    end
    m_val[k]  = v;
    m_trig[k] = t;
    m_err[k]  = e;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  // ---------------------------------------------------------------------------
  // Comparison
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [31:0] dv [3];
    logic        dt [3];
    logic        de [3];
    logic        da [3];
    forever begin
      @(negedge clk);
      if (chk_en) begin
        dv[0] = {24'd0, val_a}; dv[1] = {24'd0, val_b}; dv[2] = {20'd0, val_c};
        dt[0] = trig_a; dt[1] = trig_b; dt[2] = trig_c;
        de[0] = err_a;  de[1] = err_b;  de[2] = err_c;
        da[0] = atl_a;  da[1] = atl_b;  da[2] = atl_c;
        for (int k = 0; k < 3; k++) begin
          check($sformatf("model_value[%0d]", k), dv[k], int2bcd(m_val[k], p_dig[k]));
          check($sformatf("model_trig[%0d]", k), {31'd0, dt[k]}, {31'd0, m_trig[k]});
          check($sformatf("model_err[%0d]", k), {31'd0, de[k]}, {31'd0, m_err[k]});
          check($sformatf("model_at_limit[%0d]", k), {31'd0, da[k]},
                {31'd0, (m_val[k] == eff_lim(k))});
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; trg[k] = 1'b0; aup[k] = 1'b0; adn[k] = 1'b0; ld[k] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; trg[k] = 1'b0; dir[k] = 1'b0; aup[k] = 1'b0;
      adn[k] = 1'b0; ld[k] = 1'b0; ldv[k] = 16'h0; lim[k] = 16'h0;
    end
    lim[1] = 16'h31;
    step();
    chk_en = 1'b1;
    check("rst_val_a", {24'd0, val_a}, 32'h00);
    check("rst_val_b", {24'd0, val_b}, 32'h01);
    check("rst_val_c", {20'd0, val_c}, 32'h000);
    check("rst_trig_a", {31'd0, trig_a}, 32'd0);
    check("rst_err_a", {31'd0, err_a}, 32'd0);

    // Instance A: 60 back-to-back triggers from reset
    for (int i = 1; i <= 60; i++) begin
      trg[0] = 1'b1;
      step();
      if (i == 9)  check("a_count_09", {24'd0, val_a}, 32'h09);
      if (i == 10) check("a_09_to_10", {24'd0, val_a}, 32'h10);
      if (i == 59) begin
        check("a_58_to_59", {24'd0, val_a}, 32'h59);
        check("a_no_pulse_59", {31'd0, trig_a}, 32'd0);
      end
      if (i == 60) begin
        check("a_59_to_00", {24'd0, val_a}, 32'h00);
        check("a_pulse_wrap", {31'd0, trig_a}, 32'd1);
      end
    end
    step();
    check("a_pulse_one_cycle", {31'd0, trig_a}, 32'd0);

    adn[0] = 1'b1; step();
    check("a_adjdn_00", {24'd0, val_a}, 32'h59);
    check("a_adjdn_nopulse", {31'd0, trig_a}, 32'd0);
    aup[0] = 1'b1; step();
    check("a_adjup_59", {24'd0, val_a}, 32'h00);
    check("a_adjup_nopulse", {31'd0, trig_a}, 32'd0);
    ld[0] = 1'b1; ldv[0] = 16'h05; step();
    check("a_load_05", {24'd0, val_a}, 32'h05);
    aup[0] = 1'b1; trg[0] = 1'b1; step();
    check("a_adj_trig_06", {24'd0, val_a}, 32'h06);
    check("a_adj_trig_drop", {31'd0, trig_a}, 32'd0);

    ld[0] = 1'b1; ldv[0] = 16'h7A; step();
    check("a_load7A_err", {31'd0, err_a}, 32'd1);
    check("a_load7A_val", {24'd0, val_a}, 32'h06);
    ld[0] = 1'b1; ldv[0] = 16'h60; step();
    check("a_load60_err", {31'd0, err_a}, 32'd1);
    check("a_load60_val", {24'd0, val_a}, 32'h06);
    ld[0] = 1'b1; ldv[0] = 16'h45; step();
    check("a_load45_val", {24'd0, val_a}, 32'h45);
    check("a_load45_noerr", {31'd0, err_a}, 32'd0);

    ld[0] = 1'b1; ldv[0] = 16'h00; step();
    dir[0] = 1'b1; trg[0] = 1'b1; step();
    check("a_down_00", {24'd0, val_a}, 32'h59);
    check("a_borrow_pulse", {31'd0, trig_a}, 32'd1);
    ld[0] = 1'b1; ldv[0] = 16'h10; step();
    trg[0] = 1'b1; step();
    check("a_down_10", {24'd0, val_a}, 32'h09);
    check("a_down_10_nopulse", {31'd0, trig_a}, 32'd0);
    dir[0] = 1'b0;

    // Instance B: runtime limit, clamp and fallback
    ld[1] = 1'b1; ldv[1] = 16'h31; step();
    check("b_load_31", {24'd0, val_b}, 32'h31);
    check("b_at_limit_31", {31'd0, atl_b}, 32'd1);
    lim[1] = 16'h30; step();
    check("b_clamp_30", {24'd0, val_b}, 32'h30);
    check("b_clamp_nopulse", {31'd0, trig_b}, 32'd0);
    trg[1] = 1'b1; step();
    check("b_wrap_01", {24'd0, val_b}, 32'h01);
    check("b_wrap_pulse", {31'd0, trig_b}, 32'd1);
    lim[1] = 16'h00; ld[1] = 1'b1; ldv[1] = 16'h31; step();
    check("b_lim00_load31", {24'd0, val_b}, 32'h31);
    check("b_lim00_atlim", {31'd0, atl_b}, 32'd1);
    lim[1] = 16'h3A; step();
    check("b_lim3A_noclamp", {24'd0, val_b}, 32'h31);
    trg[1] = 1'b1; step();
    check("b_lim3A_wrap", {24'd0, val_b}, 32'h01);
    check("b_lim3A_pulse", {31'd0, trig_b}, 32'd1);
    lim[1] = 16'h31; ld[1] = 1'b1; ldv[1] = 16'h31; step();
    lim[1] = 16'h30; trg[1] = 1'b1; step();
    check("b_clamp_trig_val", {24'd0, val_b}, 32'h30);
    check("b_clamp_trig_drop", {31'd0, trig_b}, 32'd0);

    // Instance C: 3 digits, wrap, reset during counting
    ld[2] = 1'b1; ldv[2] = 16'h998; step();
    trg[2] = 1'b1; step();
    check("c_999", {20'd0, val_c}, 32'h999);
    trg[2] = 1'b1; step();
    check("c_wrap_000", {20'd0, val_c}, 32'h000);
    check("c_wrap_pulse", {31'd0, trig_c}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      trg[2] = 1'b1; step();
    end
    check("c_count_003", {20'd0, val_c}, 32'h003);
    rst[2] = 1'b1; trg[2] = 1'b1; step();
    check("c_rst_val", {20'd0, val_c}, 32'h000);
    check("c_rst_trig", {31'd0, trig_c}, 32'd0);
    dir[2] = 1'b1; trg[2] = 1'b1; step();
    check("c_down_999", {20'd0, val_c}, 32'h999);
    check("c_down_pulse", {31'd0, trig_c}, 32'd1);
    dir[2] = 1'b0;
    ld[2] = 1'b1; ldv[2] = 16'h999; step();
    rst[2] = 1'b1; trg[2] = 1'b1; step();
    check("c_rst_wrap_val", {20'd0, val_c}, 32'h000);
    check("c_rst_wrap_trig", {31'd0, trig_c}, 32'd0);

    step();
    step();
    @(negedge clk);
    chk_en = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
